mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multicycle datapath's memory port: it accepts one word request at a time (address, write data, write enable), waits a fixed number of cycles, then performs the access and returns read data with a one-cycle ready pulse. It sits between the datapath's `Adr`/`WriteData`/`ReadData` port and a unified instruction/data word array, replacing the zero-latency memory model. The controller stalls on `MemReady`.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words; power of two, 4..4096.
- `WAIT_CYCLES`, default 1: wait states inserted before each access; 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `MemReq`  in  1  request strobe; sampled only while `Busy` is low.
- `MemWrite`  in  1  1 = write, 0 = read; sampled with `MemReq`.
- `Adr`  in  32  byte address; sampled with `MemReq`.
- `WriteData`  in  32  store data; sampled with `MemReq`.
- `ReadData`  out  32  read result; valid in the `MemReady` cycle and held afterwards.
- `MemReady`  out  1  one-cycle completion pulse.
- `MemErr`  out  1  one-cycle error pulse, coincident with `MemReady`.
- `Busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On `MemReq`=1, latch `Adr`, `WriteData` and `MemWrite`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES`>0, otherwise go to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- **Access**
  - Performed on the edge that enters RESP.
  - Write: array[idx] <= latched data. `ReadData` is unchanged.
  - Read: `ReadData` <= array[idx].
- **RESP**
  - `MemReady`=1 for exactly this cycle, then return to IDLE.
  - `MemReq` is ignored while in RESP.
- **Index and address checks**
  - idx = `Adr[log2(DEPTH_WORDS)+1:2]`.
  - Error if `Adr[1:0]`≠0 or any `Adr` bit above the index field is 1.
  - On error: no array write, `ReadData` <= 32'h0000_0000, `MemErr`=1 in the RESP cycle.
- **Ignored requests**: `MemReq` while `Busy`=1 is ignored, with no queuing. The requester must hold or re-assert `MemReq` after `Busy` falls.
- **Array**: no reset; contents are undefined at power-up and preserved across `reset`.

## Timing
- **Reset values**: state IDLE, `ReadData`=0, `MemReady`=0, `MemErr`=0, `Busy`=0, counter 0.
- **Reset mid-transaction**: the pending access is discarded and no write occurs. Only the array keeps its contents.
- **Latency**: request sampled at edge N, so `MemReady` is high in cycle N+1+`WAIT_CYCLES`.
- **Throughput**: one request per `WAIT_CYCLES`+2 cycles, because IDLE must be revisited before the next accept.
- **Read after write**: a read issued right after a write's `MemReady` returns the new data.
- **Simultaneous events**
  - `MemReq` held high continuously: the next request is accepted in the first IDLE cycle after RESP.
  - `reset` asserted together with `MemReq`: reset wins.

## Structure
- Package `mem_pkg` holds:
  - the FSM state enum `mem_state_t` (IDLE, WAIT, RESP);
  - `ERR_RDATA` = 32'h0;
  - the `WAIT_CYCLES` upper limit constant (15).
- Sub-module `mem_array` is a single-port synchronous word RAM with ports `clk`, `we`, `addr`, `wd`, `rd`, and no reset. The controller, counter and address checks live in `mem_responder`.
- The counter is 4 bits wide. Range checking is derived from `DEPTH_WORDS` via `$clog2`.

## Test plan
- **Basic write/read, `WAIT_CYCLES`=1**
  - Write 32'hCAFE_F00D to `Adr` 32'h10: `MemReady` 2 cycles after the accepting edge, `ReadData` unchanged.
  - Read 32'h10: `ReadData`=32'hCAFE_F00D with `MemReady`, `MemErr`=0.
- **Latency sweep, `WAIT_CYCLES`=0, 3, 15**: `MemReady` lands exactly 1+W cycles after accept. `Busy` is high for 1+W cycles.
- **Error cases, `DEPTH_WORDS`=64**
  - Read `Adr` 32'h0000_0102 (misaligned): `MemErr`=`MemReady`=1, `ReadData`=0.
  - Write `Adr` 32'h0000_0100 (out of range): error pulse, and a later read of 32'h0 is unchanged.
- **Busy handling**: pulse `MemReq` during WAIT and again during RESP. Both are ignored, and exactly one `MemReady` is produced.
- **Held request**: hold `MemReq` high for 3 back-to-back reads of 32'h0, 32'h4, 32'h8. `MemReady` pulses are spaced W+2 cycles apart with the correct data.
- **Reset mid-write**: assert `reset` in WAIT of a write of 32'h1234_5678 to 32'h20. All outputs go to 0 immediately, and a subsequent read of 32'h20 returns the old data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;
  localparam int unsigned WAIT_MAX = 15;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; contents survive reset and are undefined at power-up.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wd,
  output logic [31:0]                    rd
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    rd <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one word request, waits WAIT_CYCLES, then accesses
// the array and pulses MemReady (with MemErr on a bad address) for one cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        Busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("WAIT_CYCLES out of range");
  end

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, wd_q, rdata_q;
  logic        we_q, err_q;
  logic        go_resp;
  logic [31:0] acc_adr, acc_wd, arr_rd;
  logic        acc_we, acc_err, arr_we;

  // With zero wait states the access happens on the accepting edge, so use the live inputs.
  assign acc_adr = (state_q == IDLE) ? Adr : adr_q;
  assign acc_wd  = (state_q == IDLE) ? WriteData : wd_q;
  assign acc_we  = (state_q == IDLE) ? MemWrite : we_q;
  assign acc_err = (|acc_adr[1:0]) | (|acc_adr[31:AW+2]);
  assign arr_we  = go_resp & acc_we & ~acc_err & reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemReq) begin
          cnt_d = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'h0;
      wd_q    <= 32'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && MemReq) begin
        adr_q <= Adr;
        wd_q  <= WriteData;
        we_q  <= MemWrite;
      end
      if (go_resp) begin
        err_q <= acc_err;
      end
      if (state_q == RESP) begin
        rdata_q <= ReadData;
      end
    end
  end

  always_comb begin
    ReadData = rdata_q;
    if (state_q == RESP) begin
      if (err_q) begin
        ReadData = ERR_RDATA;
      end else if (!we_q) begin
        ReadData = arr_rd;
      end
    end
  end

  assign MemReady = (state_q == RESP);
  assign MemErr   = MemReady & err_q;
  assign Busy     = (state_q != IDLE);

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .addr(acc_adr[AW+1:2]),
    .wd  (acc_wd),
    .rd  (arr_rd)
  );

endmodule
